// File: rtl/book_price_tracker.sv
// book_price_tracker
//
// Order book with a per-stock best-price tracker. Up to DEPTH live orders are
// held in a small on-chip table, and the order id of an entry is its index.
// A command (ADD / CANCEL / TRADE) is accepted in IDLE and executed in EXEC.
// The table is then rescanned, one entry per cycle, to rebuild the best bid
// and best ask of the one stock the command touched.
//
// Ports
//   clk_100mhz, reset_n      : system clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    : command handshake (ready only in IDLE)
//   cmd_op                   : 00 ADD, 01 CANCEL, 10 TRADE, 11 reserved
//   cmd_stock/side/price     : new order attributes (ADD)
//   cmd_quantity             : ADD size or TRADE fill size
//   cmd_order_id             : target entry (CANCEL / TRADE)
//   rsp_valid/error/order_id/quantity : one-cycle response
//   best_bid / best_ask      : flattened per-stock best prices
//   bid_present/ask_present  : per-stock "side has a live order"
//   best_price_valid/best_stock : strobe + stock of the last refresh
//   book_full                : every table entry is live
module book_price_tracker #(
    parameter int NUM_STOCKS = 4,
    parameter int DEPTH      = 16,
    parameter int PRICE_W    = 16,
    parameter int QTY_W      = 16,
    parameter int STOCK_W    = $clog2(NUM_STOCKS),
    parameter int ORDER_W    = $clog2(DEPTH)
) (
    input  logic                          clk_100mhz,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [STOCK_W-1:0]            cmd_stock,
    input  logic                          cmd_side,
    input  logic [PRICE_W-1:0]            cmd_price,
    input  logic [QTY_W-1:0]              cmd_quantity,
    input  logic [ORDER_W-1:0]            cmd_order_id,
    output logic                          rsp_valid,
    output logic                          rsp_error,
    output logic [ORDER_W-1:0]            rsp_order_id,
    output logic [QTY_W-1:0]              rsp_quantity,
    output logic [NUM_STOCKS*PRICE_W-1:0] best_bid,
    output logic [NUM_STOCKS*PRICE_W-1:0] best_ask,
    output logic [NUM_STOCKS-1:0]         bid_present,
    output logic [NUM_STOCKS-1:0]         ask_present,
    output logic                          best_price_valid,
    output logic [STOCK_W-1:0]            best_stock,
    output logic                          book_full
);

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_CANCEL = 2'b01;
    localparam logic [1:0] OP_TRADE  = 2'b10;
    localparam logic [ORDER_W-1:0] LAST_IDX = ORDER_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, SCAN} state_t;

    state_t state_reg;

    // Captured command
    logic [1:0]         op_reg;
    logic [STOCK_W-1:0] stock_reg;
    logic               side_reg;
    logic [PRICE_W-1:0] price_reg;
    logic [QTY_W-1:0]   qty_reg;
    logic [ORDER_W-1:0] id_reg;

    // Order table
    logic [DEPTH-1:0]   entry_valid_reg;
    logic [DEPTH-1:0]   entry_side_reg;
    logic [STOCK_W-1:0] entry_stock_reg [DEPTH];
    logic [PRICE_W-1:0] entry_price_reg [DEPTH];
    logic [QTY_W-1:0]   entry_qty_reg   [DEPTH];

    // Scan state and the response held back until the scan completes
    logic [ORDER_W-1:0] scan_idx_reg;
    logic [STOCK_W-1:0] scan_stock_reg;
    logic [PRICE_W-1:0] bid_acc_reg;
    logic [PRICE_W-1:0] ask_acc_reg;
    logic               bid_found_reg;
    logic               ask_found_reg;
    logic [ORDER_W-1:0] pend_id_reg;
    logic [QTY_W-1:0]   pend_qty_reg;

    // Per-stock published results
    logic [PRICE_W-1:0] best_bid_reg [NUM_STOCKS];
    logic [PRICE_W-1:0] best_ask_reg [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] bid_present_reg;
    logic [NUM_STOCKS-1:0] ask_present_reg;

    assign cmd_ready = (state_reg == IDLE);
    assign book_full = &entry_valid_reg;

    // Lowest-index free entry for ADD
    logic [ORDER_W-1:0] free_idx;
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entry_valid_reg[i]) free_idx = ORDER_W'(i);
        end
    end

    // Target entry lookup and EXEC validation
    logic               id_in_range;
    logic               target_valid;
    logic [QTY_W-1:0]   target_qty;
    logic [STOCK_W-1:0] target_stock;
    logic               stock_bad;
    logic               exec_error;

    always_comb begin
        id_in_range  = int'(id_reg) < DEPTH;
        target_valid = id_in_range && entry_valid_reg[id_reg];
        target_qty   = entry_qty_reg[id_reg];
        target_stock = entry_stock_reg[id_reg];
        stock_bad    = int'(stock_reg) >= NUM_STOCKS;
        case (op_reg)
            OP_ADD:    exec_error = book_full || (qty_reg == '0) || stock_bad;
            OP_CANCEL: exec_error = !target_valid;
            OP_TRADE:  exec_error = !target_valid || (qty_reg == '0);
            default:   exec_error = 1'b1;
        endcase
    end

    // Scan step: fold the current entry into the running max-bid / min-ask.
    logic               scan_hit;
    logic               scan_side;
    logic [PRICE_W-1:0] scan_price;
    logic [PRICE_W-1:0] bid_next;
    logic [PRICE_W-1:0] ask_next;
    logic               bid_found_next;
    logic               ask_found_next;
    logic               publish;

    always_comb begin
        scan_side      = entry_side_reg[scan_idx_reg];
        scan_price     = entry_price_reg[scan_idx_reg];
        scan_hit       = entry_valid_reg[scan_idx_reg] &&
                         (entry_stock_reg[scan_idx_reg] == scan_stock_reg);
        bid_next       = (scan_hit && !scan_side && scan_price > bid_acc_reg) ? scan_price : bid_acc_reg;
        ask_next       = (scan_hit &&  scan_side && scan_price < ask_acc_reg) ? scan_price : ask_acc_reg;
        bid_found_next = bid_found_reg | (scan_hit & !scan_side);
        ask_found_next = ask_found_reg | (scan_hit &  scan_side);
        publish        = (state_reg == SCAN) && (scan_idx_reg == LAST_IDX);
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            op_reg           <= '0;
            stock_reg        <= '0;
            side_reg         <= 1'b0;
            price_reg        <= '0;
            qty_reg          <= '0;
            id_reg           <= '0;
            entry_valid_reg  <= '0;
            entry_side_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_stock_reg[i] <= '0;
                entry_price_reg[i] <= '0;
                entry_qty_reg[i]   <= '0;
            end
            scan_idx_reg     <= '0;
            scan_stock_reg   <= '0;
            bid_acc_reg      <= '0;
            ask_acc_reg      <= '1;
            bid_found_reg    <= 1'b0;
            ask_found_reg    <= 1'b0;
            pend_id_reg      <= '0;
            pend_qty_reg     <= '0;
            rsp_valid        <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_order_id     <= '0;
            rsp_quantity     <= '0;
            best_price_valid <= 1'b0;
            best_stock       <= '0;
        end else begin
            rsp_valid        <= 1'b0;
            best_price_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg    <= cmd_op;
                        stock_reg <= cmd_stock;
                        side_reg  <= cmd_side;
                        price_reg <= cmd_price;
                        qty_reg   <= cmd_quantity;
                        id_reg    <= cmd_order_id;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_error) begin
                        // Rejected: table untouched, respond now, no rescan.
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b1;
                        rsp_order_id <= id_reg;
                        rsp_quantity <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        case (op_reg)
                            OP_ADD: begin
                                entry_valid_reg[free_idx] <= 1'b1;
                                entry_side_reg[free_idx]  <= side_reg;
                                entry_stock_reg[free_idx] <= stock_reg;
                                entry_price_reg[free_idx] <= price_reg;
                                entry_qty_reg[free_idx]   <= qty_reg;
                                pend_id_reg               <= free_idx;
                                pend_qty_reg              <= qty_reg;
                                scan_stock_reg            <= stock_reg;
                            end
                            OP_CANCEL: begin
                                entry_valid_reg[id_reg] <= 1'b0;
                                pend_id_reg             <= id_reg;
                                pend_qty_reg            <= '0;
                                scan_stock_reg          <= target_stock;
                            end
                            default: begin
                                // TRADE: a fill at or above the resting size removes the order.
                                if (qty_reg >= target_qty) begin
                                    entry_valid_reg[id_reg] <= 1'b0;
                                    pend_qty_reg            <= '0;
                                end else begin
                                    entry_qty_reg[id_reg] <= target_qty - qty_reg;
                                    pend_qty_reg          <= target_qty - qty_reg;
                                end
                                pend_id_reg    <= id_reg;
                                scan_stock_reg <= target_stock;
                            end
                        endcase
                        scan_idx_reg  <= '0;
                        bid_acc_reg   <= '0;
                        ask_acc_reg   <= '1;
                        bid_found_reg <= 1'b0;
                        ask_found_reg <= 1'b0;
                        state_reg     <= SCAN;
                    end
                end
                SCAN: begin
                    bid_acc_reg   <= bid_next;
                    ask_acc_reg   <= ask_next;
                    bid_found_reg <= bid_found_next;
                    ask_found_reg <= ask_found_next;
                    if (publish) begin
                        rsp_valid        <= 1'b1;
                        rsp_error        <= 1'b0;
                        rsp_order_id     <= pend_id_reg;
                        rsp_quantity     <= pend_qty_reg;
                        best_price_valid <= 1'b1;
                        best_stock       <= scan_stock_reg;
                        state_reg        <= IDLE;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Only the scanned stock's slot is rewritten; other stocks hold.
    generate
        for (genvar gi = 0; gi < NUM_STOCKS; gi++) begin : g_stock
            always_ff @(posedge clk_100mhz or negedge reset_n) begin
                if (!reset_n) begin
                    best_bid_reg[gi]    <= '0;
                    best_ask_reg[gi]    <= '1;
                    bid_present_reg[gi] <= 1'b0;
                    ask_present_reg[gi] <= 1'b0;
                end else if (publish && (scan_stock_reg == STOCK_W'(gi))) begin
                    // An empty side naturally leaves the accumulator at 0 / all ones.
                    best_bid_reg[gi]    <= bid_next;
                    best_ask_reg[gi]    <= ask_next;
                    bid_present_reg[gi] <= bid_found_next;
                    ask_present_reg[gi] <= ask_found_next;
                end
            end
            assign best_bid[gi*PRICE_W +: PRICE_W] = best_bid_reg[gi];
            assign best_ask[gi*PRICE_W +: PRICE_W] = best_ask_reg[gi];
            assign bid_present[gi] = bid_present_reg[gi];
            assign ask_present[gi] = ask_present_reg[gi];
        end
    endgenerate

endmodule

// File: doc/book_price_tracker.md
# book_price_tracker

Parametrised order book plus best-price tracker for NUM_STOCKS instruments, sitting between the feed/order decoder and the trading logic. Holds up to DEPTH live orders in an on-chip table, executes ADD / CANCEL / TRADE commands over a valid/ready handshake, then rescans the table to publish per-stock best bid and best ask with a one-cycle update strobe. It generalises the fixed single-book builder with channel count, depth and widths as parameters, separate bid/ask sides, partial fills, error reporting and a full flag.

## Interface
- NUM_STOCKS, 4, number of instruments (≥2)
- DEPTH, 16, order-table entries (≥2)
- PRICE_W, 16, price width
- QTY_W, 16, quantity width
- STOCK_W, $clog2(NUM_STOCKS), stock index width
- ORDER_W, $clog2(DEPTH), order id width

- clk_100mhz  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; equals (state == IDLE)
- cmd_op  in  2  00 ADD, 01 CANCEL, 10 TRADE, 11 reserved
- cmd_stock  in  STOCK_W  instrument (ADD only)
- cmd_side  in  1  0 buy, 1 sell (ADD only)
- cmd_price  in  PRICE_W  limit price (ADD only)
- cmd_quantity  in  QTY_W  ADD size / TRADE fill size
- cmd_order_id  in  ORDER_W  target order (CANCEL/TRADE)
- rsp_valid  out  1  one-cycle response strobe
- rsp_error  out  1  command rejected; qualified by rsp_valid
- rsp_order_id  out  ORDER_W  allocated id (ADD) or target id
- rsp_quantity  out  QTY_W  remaining quantity after command (0 if removed)
- best_bid  out  NUM_STOCKS*PRICE_W  flattened, stock s at [s*PRICE_W +: PRICE_W]
- best_ask  out  NUM_STOCKS*PRICE_W  flattened, same packing
- bid_present / ask_present  out  NUM_STOCKS each  side has ≥1 live order
- best_price_valid  out  1  one-cycle strobe: best_* for best_stock just updated
- best_stock  out  STOCK_W  stock refreshed by last strobe
- book_full  out  1  all DEPTH entries live

## Operation
- Entry: valid, stock, side, price, quantity. Order id = entry index.
- States: IDLE → EXEC → SCAN → IDLE; EXEC → IDLE on error.
- IDLE: on cmd_valid && cmd_ready capture all cmd_* fields.
- EXEC (one cycle), validation then action:
  - ADD: error if book_full, cmd_quantity==0, or cmd_stock ≥ NUM_STOCKS; else write lowest-index free entry, rsp_order_id = that index, rsp_quantity = cmd_quantity.
  - CANCEL: error if cmd_order_id ≥ DEPTH or entry not valid; else clear valid, rsp_quantity = 0.
  - TRADE: error if entry not valid or cmd_quantity==0; if cmd_quantity ≥ entry quantity clear entry, rsp_quantity = 0; else entry quantity −= cmd_quantity, rsp_quantity = difference.
  - Reserved op: error.
  - Scan stock = cmd_stock (ADD) or stored stock of the entry (CANCEL/TRADE).
- SCAN: index 0..DEPTH−1, one entry per cycle, reading the table as updated by EXEC. Bid accumulator = max price over valid buys of scan stock; ask = min price over valid sells. On last index write best_bid/best_ask/present for scan stock only, pulse best_price_valid with best_stock, pulse rsp_valid, return to IDLE.
- Empty side: best_bid = 0 and bid_present = 0; best_ask = all ones and ask_present = 0.
- Equal prices: value identical regardless of which entry wins; no tie ordering required.
- Error: table and best_* unchanged, no best_price_valid strobe.
- cmd_valid while cmd_ready low is ignored; producer holds the command.

## Timing
- Reset (reset_n low, asynchronous): all entries invalid, state IDLE, rsp_valid 0, rsp_error 0, rsp_order_id 0, rsp_quantity 0, best_bid all 0, best_ask all ones, bid_present/ask_present 0, best_price_valid 0, best_stock 0, book_full 0. cmd_ready reads 1 but commands are dropped while reset_n is low.
- Reset mid-command: command aborted, no response, everything returns to reset values.
- Acceptance at edge E0. Error: rsp_valid/rsp_error high the cycle after E1, cmd_ready high the same cycle.
- Success: table updated at E1; rsp_valid and best_price_valid high together for one cycle after E(DEPTH+1); cmd_ready high in that same cycle, allowing back-to-back commands with DEPTH+2 cycle spacing.
- book_full reflects the table combinationally, one cycle after the EXEC write.

## Test plan
- NUM_STOCKS=2, DEPTH=4: after reset ADD s0 buy 100 qty 10 → rsp id 0, qty 10; 5 cycles later best_bid[0]=100, bid_present[0]=1, best_ask[0]=0xFFFF, best_stock=0.
- ADD s0 buy 105, ADD s0 sell 110, ADD s0 sell 108 → ids 1,2,3; book_full=1; best_bid[0]=105, best_ask[0]=108; a fifth ADD gives rsp_error=1 with no strobe.
- TRADE id 3 qty 4 on a qty-10 order → rsp_quantity 6, ask still 108; TRADE id 3 qty 6 → entry removed, best_ask[0]=110, book_full=0.
- CANCEL id 1 → best_bid[0]=100; CANCEL id 1 again → rsp_error=1; op 11 → rsp_error=1.
- ADD s1 sell 50 → only stock 1 fields change, best_stock=1; stock 0 outputs stay stable.
- Assert reset_n mid-SCAN → no rsp_valid, all outputs at reset values, next ADD allocates id 0.
